// File: rtl/clk_edge_meter.sv
// Synchronizes a slow asynchronous clock/strobe into clockin, emits edge ticks,
// and measures its period and high time in clockin cycles with stall detection.
module clk_edge_meter #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clockin,
    input  logic             reset,
    input  logic             sig_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        STALL = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic [CNT_W-1:0]       run_cnt;
    logic [CNT_W-1:0]       run_nxt;
    logic [CNT_W-1:0]       hi_run;
    logic [CNT_W-1:0]       hi_pend;
    logic                   publish;
    logic                   run_sat;
    state_t                 state_q;
    state_t                 state_nxt;

    // Synchronizer chain plus one delay stage for edge decode
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    assign s         = sync_q[SYNC_STAGES-1];
    assign rise_tick = s & ~s_d;
    assign fall_tick = ~s & s_d;
    assign run_sat   = (run_cnt == CNT_MAX);

    // High-time counter runs independently of the state machine
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            hi_run  <= '0;
            hi_pend <= '0;
        end else begin
            if (rise_tick) begin
                hi_run <= CNT_ONE;
            end else if (s && (hi_run != CNT_MAX)) begin
                hi_run <= hi_run + CNT_ONE;
            end
            if (fall_tick) begin
                hi_pend <= hi_run;
            end
        end
    end

    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            run_cnt <= '0;
        end else begin
            state_q <= state_nxt;
            run_cnt <= run_nxt;
        end
    end

    // Next state and rise-to-rise counter; a rise always wins over saturation
    always_comb begin
        state_nxt = state_q;
        run_nxt   = run_cnt;
        publish   = 1'b0;
        case (state_q)
            IDLE: begin
                run_nxt = '0;
                if (rise_tick) begin
                    state_nxt = ARMED;
                    run_nxt   = CNT_ONE;
                end
            end
            ARMED, RUN: begin
                if (rise_tick) begin
                    publish   = 1'b1;
                    state_nxt = RUN;
                    run_nxt   = CNT_ONE;
                end else if (run_sat) begin
                    state_nxt = STALL;
                end else begin
                    run_nxt = run_cnt + CNT_ONE;
                end
            end
            STALL: begin
                if (rise_tick) begin
                    state_nxt = ARMED;
                    run_nxt   = CNT_ONE;
                end else if (!run_sat) begin
                    run_nxt = run_cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                run_nxt   = '0;
            end
        endcase
    end

    // Measurement and status outputs move together on the same edge
    always_ff @(posedge clockin or posedge reset) begin
        if (reset) begin
            period     <= '0;
            high_cnt   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            meas_valid <= publish;
            locked     <= (state_nxt == RUN);
            stalled    <= (state_nxt == STALL);
            if (publish) begin
                period   <= run_cnt;
                high_cnt <= hi_pend;
            end
        end
    end

endmodule
